gpr_wb_arbiter: RTL and testbench

Shares the single general-purpose register file write port between NREQ write-back requesters, e.g. ALU, load unit and mul/div unit. Each requester uses a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The winner's register number and data are registered and driven onto the register file's reg_write/num_write/data_write inputs one cycle later. It also reports in-flight writes to register 0 handling and, optionally, forwards in-flight data to the read ports.

---
 rtl/gpr_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/gpr_wb_arbiter.sv | 89 ++++++++
 tb/tb_gpr_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR write-back path.
package gpr_pkg;

  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;
  localparam logic [GPR_AW-1:0] GPR_ZERO = 5'd0;

  typedef struct packed {
    logic [GPR_AW-1:0] num;
    logic [GPR_DW-1:0] data;
  } gpr_wb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer,
// pointer moves to just past the winner; wrap is explicit so any N in 2..8 works.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;
  logic          found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'(wrap(int'(ptr) + k));
      if (advance && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
    nxt = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the register-file write port between NREQ write-back requesters with a
// one-cycle output register. Optional read-port forwarding under GPR_WB_BYPASS_EN.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = GPR_DW,
  parameter int AW   = GPR_AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_num,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
  output logic               reg_write,
  output logic [AW-1:0]      num_write,
  output logic [DW-1:0]      data_write,
  output logic [2:0]         gnt_id,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  output logic               fwd_a_hit,
  output logic               fwd_b_hit,
  output logic [DW-1:0]      fwd_data
);

  logic [NREQ-1:0] gnt;
  logic            advance;
  logic [AW-1:0]   sel_num;
  logic [DW-1:0]   sel_data;
  logic [2:0]      sel_id;

  // Holding grants off during reset keeps req_ready low for the whole reset pulse.
  assign advance = !stall && !reset;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_num  = '0;
    sel_data = '0;
    sel_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_num  = req_num[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        sel_id   = 3'(i);
      end
    end
  end

  // Register 0 requests are consumed (handshake completes) but never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      num_write  <= '0;
      data_write <= '0;
      gnt_id     <= '0;
    end else if (|gnt) begin
      reg_write  <= (sel_num != '0);
      num_write  <= sel_num;
      data_write <= sel_data;
      gnt_id     <= sel_id;
    end else begin
      reg_write  <= 1'b0;
    end
  end

`ifdef GPR_WB_BYPASS_EN
  assign fwd_a_hit = reg_write && (num_write == rs) && (rs != '0);
  assign fwd_b_hit = reg_write && (num_write == rt) && (rt != '0);
  assign fwd_data  = data_write;
`else
  logic unused_fwd_idx;
  assign unused_fwd_idx = ^{rs, rt};
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: fixed vector table, directed corner
// sequences, then randomized traffic against a queue-style reference model.
module tb_gpr_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_num;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               reg_write;
  logic [AW-1:0]      num_write;
  logic [DW-1:0]      data_write;
  logic [2:0]         gnt_id;
  logic [AW-1:0]      rs;
  logic [AW-1:0]      rt;
  logic               fwd_a_hit;
  logic               fwd_b_hit;
  logic [DW-1:0]      fwd_data;

  gpr_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_num    (req_num),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .stall      (stall),
    .reg_write  (reg_write),
    .num_write  (num_write),
    .data_write (data_write),
    .gnt_id     (gnt_id),
    .rs         (rs),
    .rt         (rt),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_data   (fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [NREQ-1:0] rdy_s;

  typedef struct {
    logic [2:0] valid;
    logic       stall;
    logic [2:0] ready;
    logic       wr;
    logic [4:0] num;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1; ready sampled mid-cycle; outputs sampled at posedge+1.
  task automatic step(input logic [2:0] v, input logic s);
    req_valid = v;
    stall     = s;
    #4;
    rdy_s = req_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #4;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_num_write", 64'(num_write), 64'd0);
    chk("rst_data_write", 64'(data_write), 64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] n, input logic [DW-1:0] d);
    req_num[i*AW +: AW]  = n;
    req_data[i*DW +: DW] = d;
  endtask

  // Reference model state
  int          m_ptr;
  logic        m_wr;
  logic [AW-1:0] m_num;
  logic [DW-1:0] m_data;
  int          m_id;
  logic        pend[NREQ];
  logic [AW-1:0] pnum[NREQ];
  logic [DW-1:0] pdata[NREQ];

  int g, wait2, max_wait, cnt2;
  logic [2:0] vv;
  logic [NREQ-1:0] exp_rdy;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_num = '0; req_data = '0;
    stall = 1'b0; rs = '0; rt = '0;
    @(posedge clock);
    #1;
    req_valid = 3'b111;
    do_reset();

    // Vector table: nums 1/2/3, data = num * 0x11
    tbl[0] = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd1, 3'd0};
    tbl[1] = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd2, 3'd1};
    tbl[2] = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd3, 3'd2};
    tbl[3] = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd1, 3'd0};
    tbl[4] = '{3'b111, 1'b1, 3'b000, 1'b0, 5'd1, 3'd0};
    tbl[5] = '{3'b100, 1'b0, 3'b100, 1'b1, 5'd3, 3'd2};
    tbl[6] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd3, 3'd2};
    tbl[7] = '{3'b011, 1'b0, 3'b001, 1'b1, 5'd1, 3'd0};
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'((i + 1) * 32'h11));
    for (int r = 0; r < 8; r++) begin
      step(tbl[r].valid, tbl[r].stall);
      chk($sformatf("tbl%0d_ready", r), 64'(rdy_s), 64'(tbl[r].ready));
      chk($sformatf("tbl%0d_wr", r), 64'(reg_write), 64'(tbl[r].wr));
      chk($sformatf("tbl%0d_num", r), 64'(num_write), 64'(tbl[r].num));
      chk($sformatf("tbl%0d_id", r), 64'(gnt_id), 64'(tbl[r].id));
      chk($sformatf("tbl%0d_data", r), 64'(data_write), 64'((tbl[r].id + 1) * 32'h11));
    end

    // Reset while a grant is pending: write discarded, pointer back to 0
    set_req(1, 5'd7, 32'hA5A5);
    req_valid = 3'b010; stall = 1'b0;
    #4;
    chk("midrst_ready_pre", 64'(req_ready), 64'b010);
    reset = 1'b1;
    #1;
    chk("midrst_ready_in", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    chk("midrst_wr", 64'(reg_write), 64'd0);
    chk("midrst_num", 64'(num_write), 64'd0);
    chk("midrst_data", 64'(data_write), 64'd0);
    chk("midrst_id", 64'(gnt_id), 64'd0);
    reset = 1'b0;
    set_req(0, 5'd1, 32'h11);
    step(3'b111, 1'b0);
    chk("midrst_ptr0", 64'(rdy_s), 64'b001);

    // Register 0 request: handshake completes, no write
    do_reset();
    set_req(2, 5'd0, 32'hDEADBEEF);
    step(3'b100, 1'b0);
    chk("r0_ready", 64'(rdy_s), 64'b100);
    chk("r0_wr", 64'(reg_write), 64'd0);
    chk("r0_id", 64'(gnt_id), 64'd2);

    // Stall after a grant: in-flight write completes, next grant goes to 1
    do_reset();
    set_req(0, 5'd9, 32'h55);
    set_req(1, 5'd10, 32'h66);
    step(3'b001, 1'b0);
    chk("stl_grant", 64'(rdy_s), 64'b001);
    chk("stl_wr", 64'(reg_write), 64'd1);
    chk("stl_num", 64'(num_write), 64'd9);
    step(3'b011, 1'b1);
    chk("stl_ready", 64'(rdy_s), 64'd0);
    chk("stl_idle_wr", 64'(reg_write), 64'd0);
    step(3'b011, 1'b0);
    chk("stl_release", 64'(rdy_s), 64'b010);
    chk("stl_rel_num", 64'(num_write), 64'd10);

    // Forwarding from the output stage
    do_reset();
    set_req(0, 5'd4, 32'h1234);
    rs = 5'd4; rt = 5'd0;
    step(3'b001, 1'b0);
`ifdef GPR_WB_BYPASS_EN
    chk("fwd_a", 64'(fwd_a_hit), 64'd1);
    chk("fwd_b", 64'(fwd_b_hit), 64'd0);
    chk("fwd_data", 64'(fwd_data), 64'h1234);
`else
    chk("fwd_a", 64'(fwd_a_hit), 64'd0);
    chk("fwd_b", 64'(fwd_b_hit), 64'd0);
    chk("fwd_data", 64'(fwd_data), 64'd0);
`endif
    rs = '0;

    // Fairness: req0 always valid, req2 valid from cycle 3 onward
    do_reset();
    wait2 = 0; max_wait = 0; cnt2 = 0;
    for (int c = 0; c < 100; c++) begin
      vv = (c >= 3) ? 3'b101 : 3'b001;
      step(vv, 1'b0);
      if (c >= 3) begin
        if (rdy_s[2]) begin
          cnt2++;
          wait2 = 0;
        end else begin
          wait2++;
          if (wait2 > max_wait) max_wait = wait2;
        end
      end
    end
    chk("fair_max_wait_le2", 64'(max_wait <= 2), 64'd1);
    chk("fair_req2_served", 64'(cnt2 >= 40), 64'd1);

    // Randomized traffic against the reference model
    do_reset();
    m_ptr = 0; m_wr = 1'b0; m_num = '0; m_data = '0; m_id = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pnum[i]  = AW'($urandom_range(0, 7));
          pdata[i] = $urandom;
        end
        set_req(i, pnum[i], pdata[i]);
        vv[i] = pend[i];
      end
      rs = AW'($urandom_range(0, 7));
      rt = AW'($urandom_range(0, 7));
      stall = ($urandom_range(0, 3) == 0);
      g = -1;
      if (!stall)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      step(vv, stall);
      chk("rnd_ready", 64'(rdy_s), 64'(exp_rdy));
      if (g >= 0) begin
        m_wr   = (pnum[g] != 0);
        m_num  = pnum[g];
        m_data = pdata[g];
        m_id   = g;
        m_ptr  = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      chk("rnd_wr", 64'(reg_write), 64'(m_wr));
      chk("rnd_num", 64'(num_write), 64'(m_num));
      chk("rnd_data", 64'(data_write), 64'(m_data));
      chk("rnd_id", 64'(gnt_id), 64'(m_id));
`ifdef GPR_WB_BYPASS_EN
      chk("rnd_fwd_a", 64'(fwd_a_hit), 64'(m_wr && m_num == rs && rs != 0));
      chk("rnd_fwd_b", 64'(fwd_b_hit), 64'(m_wr && m_num == rt && rt != 0));
      chk("rnd_fwd_d", 64'(fwd_data), 64'(m_data));
`else
      chk("rnd_fwd_a", 64'(fwd_a_hit), 64'd0);
      chk("rnd_fwd_b", 64'(fwd_b_hit), 64'd0);
      chk("rnd_fwd_d", 64'(fwd_data), 64'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
